rs_branch: RTL and testbench

RS_BRANCH -- requirements
Module: rs_branch

---
 rtl/types_pkg.sv | 47 ++++
 rtl/rs_branch_age_select.sv | 44 ++++
 rtl/rs_branch.sv | 160 ++++++++++++++++
 tb/tb_rs_branch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types and sizing for the branch reservation station.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
// Contents: RS_BRANCH_DEPTH, PREG_W, ROB_W, NUM_CDB, the rs_data uop record,
//           rob_age() for wrap-safe ordering and cdb_hit() for wakeup matching.
package types_pkg;

  localparam int RS_BRANCH_DEPTH = 8;
  localparam int PREG_W          = 7;
  localparam int ROB_W           = 5;
  localparam int NUM_CDB         = 3;  // ALU, LSU, branch writeback ports

  typedef struct packed {
    logic [ROB_W-1:0]  rob_index;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic              ps1_ready;
    logic              ps2_ready;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [31:0]       imm;
    logic [31:0]       pc;
  } rs_data;

  // Distance of a ROB index from the ROB head; smaller means older.
  // Subtraction wraps in ROB_W bits, so index 31 sorts before index 0
  // when the head sits at 30.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] idx,
                                               input logic [ROB_W-1:0] head);
    return idx - head;
  endfunction

  // True when any valid writeback port carries this tag. p0 is hardwired
  // ready, so tag 0 never wakes anything.
  function automatic logic cdb_hit(input logic [PREG_W-1:0]               tag,
                                   input logic [NUM_CDB-1:0]              vld,
                                   input logic [NUM_CDB-1:0][PREG_W-1:0]  tags);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < NUM_CDB; p++) begin
      if (vld[p] && (tags[p] == tag)) hit = 1'b1;
    end
    return hit && (tag != '0);
  endfunction

endpackage

// File: rtl/rs_branch_age_select.sv
// Oldest-first picker: returns the eligible entry closest to the ROB head.
// Latency: purely combinational, zero cycles.
// Backpressure: none; found_o is low when nothing is eligible.
// Ports: eligible_i (per-entry request), rob_index_i (per-entry ROB index),
//        curr_rob_tag_i (ROB head), found_o / index_o (winner).
module rs_age_select
  import types_pkg::*;
#(
  parameter int DEPTH = RS_BRANCH_DEPTH,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0]            eligible_i,
  input  logic [DEPTH-1:0][ROB_W-1:0] rob_index_i,
  input  logic [ROB_W-1:0]            curr_rob_tag_i,
  output logic                        found_o,
  output logic [IDX_W-1:0]            index_o
);

  logic             found_l;
  logic [IDX_W-1:0] index_l;
  logic [ROB_W-1:0] best_age;
  logic [ROB_W-1:0] age;

  // Linear scan keeping the smallest age seen; ROB indices in flight are
  // unique, so strict less-than never has to break a tie.
  always_comb begin
    found_l  = 1'b0;
    index_l  = '0;
    best_age = '1;
    age      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age = rob_age(rob_index_i[i], curr_rob_tag_i);
      if (eligible_i[i] && (!found_l || (age < best_age))) begin
        found_l  = 1'b1;
        best_age = age;
        index_l  = IDX_W'(i);
      end
    end
  end

  assign found_o = found_l;
  assign index_o = index_l;

endmodule

// File: rtl/rs_branch.sv
// Branch/JALR reservation station: holds uops until both sources are ready,
// then issues the oldest ready one to the branch FU.
// Latency: dispatch-to-issue minimum 1 cycle; issue output registered.
// Backpressure: disp_ready drops when full or during mispredict recovery;
//               issue waits on fu_b_ready.
// Ports: clk/reset (sync, active high), disp_* dispatch handshake,
//        cdb_valid/cdb_tag wakeup, fu_b_ready, mispredict/mispredict_tag
//        recovery, curr_rob_tag age origin, issued/data_out issue result.
module rs_branch
  import types_pkg::*;
#(
  parameter int DEPTH = RS_BRANCH_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             disp_valid,
  input  rs_data                           disp_data,
  output logic                             disp_ready,
  input  logic [NUM_CDB-1:0]               cdb_valid,
  input  logic [NUM_CDB-1:0][PREG_W-1:0]   cdb_tag,
  input  logic                             fu_b_ready,
  input  logic                             mispredict,
  input  logic [ROB_W-1:0]                 mispredict_tag,
  input  logic [ROB_W-1:0]                 curr_rob_tag,
  output logic                             issued,
  output rs_data                           data_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // State
  logic [DEPTH-1:0] valid_q, valid_d;
  rs_data           ent_q [DEPTH];
  rs_data           ent_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             issued_q, issued_d;
  rs_data           data_out_q, data_out_d;

  // Combinational helpers
  rs_data                    woke [DEPTH];
  rs_data                    disp_woke;
  logic [DEPTH-1:0]          eligible;
  logic [DEPTH-1:0][ROB_W-1:0] rob_vec;
  logic                      sel_found;
  logic [IDX_W-1:0]          sel_idx;
  logic [ROB_W-1:0]          sel_age;
  logic [ROB_W-1:0]          flush_age;
  logic                      issue_go;
  logic                      free_found;
  logic [IDX_W-1:0]          free_idx;
  logic                      disp_go;

  // Wakeup is applied to stored entries and to the uop being dispatched.
  // Eligibility below looks only at the registered ready bits, so a wakeup
  // seen this cycle makes an entry issuable next cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (valid_q[i]) begin
        if (cdb_hit(ent_q[i].ps1, cdb_valid, cdb_tag)) woke[i].ps1_ready = 1'b1;
        if (cdb_hit(ent_q[i].ps2, cdb_valid, cdb_tag)) woke[i].ps2_ready = 1'b1;
      end
    end
    disp_woke = disp_data;
    if (cdb_hit(disp_data.ps1, cdb_valid, cdb_tag)) disp_woke.ps1_ready = 1'b1;
    if (cdb_hit(disp_data.ps2, cdb_valid, cdb_tag)) disp_woke.ps2_ready = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      eligible[i] = valid_q[i] && ent_q[i].ps1_ready && ent_q[i].ps2_ready;
      rob_vec[i]  = ent_q[i].rob_index;
    end
  end

  rs_age_select #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_age_select (
    .eligible_i     (eligible),
    .rob_index_i    (rob_vec),
    .curr_rob_tag_i (curr_rob_tag),
    .found_o        (sel_found),
    .index_o        (sel_idx)
  );

  // Anything younger than the mispredicting branch is on the wrong path,
  // including the candidate we were about to issue.
  assign flush_age = rob_age(mispredict_tag, curr_rob_tag);
  assign sel_age   = rob_age(rob_vec[sel_idx], curr_rob_tag);
  assign issue_go  = fu_b_ready && sel_found && !(mispredict && (sel_age > flush_age));

  assign disp_ready = (count_q < CNT_W'(DEPTH)) && !mispredict;

  // Lowest free slot, judged on registered valids: a slot vacated by this
  // cycle's issue or flush is not handed out until next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_go = disp_valid && disp_ready && free_found;

  always_comb begin
    valid_d    = valid_q;
    ent_d      = woke;
    data_out_d = data_out_q;
    issued_d   = issue_go;
    count_d    = '0;

    if (issue_go) begin
      valid_d[sel_idx] = 1'b0;
      data_out_d       = woke[sel_idx];
    end

    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rob_age(ent_q[i].rob_index, curr_rob_tag) > flush_age) valid_d[i] = 1'b0;
      end
    end

    if (disp_go) begin
      valid_d[free_idx] = 1'b1;
      ent_d[free_idx]   = disp_woke;
    end

    // Count tracks the next valid set, which already folds in
    // dispatch, issue and flush for this cycle.
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
  end

  // Entry payload needs no reset: valid gates every use of it.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
    if (reset) begin
      valid_q    <= '0;
      count_q    <= '0;
      issued_q   <= 1'b0;
      data_out_q <= '0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      data_out_q <= data_out_d;
    end
  end

  assign issued   = issued_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_rs_branch.sv
// Self-checking bench for rs_branch: directed scenarios then random traffic,
// compared cycle by cycle against a queue-based reference model.
// Latency: n/a. Backpressure: n/a.
module tb_rs_branch;
  import types_pkg::*;

  logic                           clk;
  logic                           reset;
  logic                           disp_valid;
  rs_data                         disp_data;
  logic                           disp_ready;
  logic [NUM_CDB-1:0]             cdb_valid;
  logic [NUM_CDB-1:0][PREG_W-1:0] cdb_tag;
  logic                           fu_b_ready;
  logic                           mispredict;
  logic [ROB_W-1:0]               mispredict_tag;
  logic [ROB_W-1:0]               curr_rob_tag;
  logic                           issued;
  rs_data                         data_out;

  rs_branch #(.DEPTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .disp_valid     (disp_valid),
    .disp_data      (disp_data),
    .disp_ready     (disp_ready),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .fu_b_ready     (fu_b_ready),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .curr_rob_tag   (curr_rob_tag),
    .issued         (issued),
    .data_out       (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: the station as an unordered bag of uops.
  rs_data m_q[$];
  logic   m_iss;
  rs_data m_dout;

  function automatic bit wakes(input logic [PREG_W-1:0] t);
    if (t == 0) return 1'b0;
    for (int p = 0; p < NUM_CDB; p++)
      if (cdb_valid[p] && cdb_tag[p] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic rs_data wake_uop(input rs_data u);
    rs_data r;
    r = u;
    if (wakes(u.ps1)) r.ps1_ready = 1'b1;
    if (wakes(u.ps2)) r.ps2_ready = 1'b1;
    return r;
  endfunction

  function automatic rs_data mk(input int rob, input int s1, input bit r1,
                                input int s2, input bit r2);
    rs_data u;
    u.rob_index = ROB_W'(rob);
    u.pd        = PREG_W'($urandom);
    u.ps1       = PREG_W'(s1);
    u.ps2       = PREG_W'(s2);
    u.ps1_ready = r1;
    u.ps2_ready = r2;
    u.opcode    = 7'($urandom);
    u.funct3    = 3'($urandom);
    u.imm       = $urandom;
    u.pc        = $urandom;
    return u;
  endfunction

  // One clock: inputs are already set (we are at a falling edge).
  task automatic step();
    bit               exp_rdy;
    int               best;
    logic [ROB_W-1:0] bage, mage, a;
    #1;
    exp_rdy = (m_q.size() < 8) && !mispredict;
    if (!reset) chk("disp_ready", 128'(disp_ready), 128'(exp_rdy));
    if (reset) begin
      m_q.delete();
      m_iss  = 1'b0;
      m_dout = '0;
    end else begin
      best = -1;
      bage = '0;
      for (int i = 0; i < m_q.size(); i++) begin
        a = ROB_W'(m_q[i].rob_index - curr_rob_tag);
        if (m_q[i].ps1_ready && m_q[i].ps2_ready && (best < 0 || a < bage)) begin
          best = i;
          bage = a;
        end
      end
      mage  = ROB_W'(mispredict_tag - curr_rob_tag);
      m_iss = fu_b_ready && (best >= 0) && !(mispredict && bage > mage);
      foreach (m_q[i]) m_q[i] = wake_uop(m_q[i]);
      if (m_iss) begin
        m_dout = m_q[best];
        m_q.delete(best);
      end
      if (mispredict) begin
        for (int i = m_q.size() - 1; i >= 0; i--) begin
          a = ROB_W'(m_q[i].rob_index - curr_rob_tag);
          if (a > mage) m_q.delete(i);
        end
      end
      if (disp_valid && exp_rdy) m_q.push_back(wake_uop(disp_data));
    end
    @(posedge clk);
    #1;
    chk("issued", 128'(issued), 128'(m_iss));
    chk("data_out", 128'(data_out), 128'(m_dout));
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = '0;
    mispredict = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic disp(input rs_data u);
    disp_valid = 1'b1;
    disp_data  = u;
    step();
    disp_valid = 1'b0;
  endtask

  function automatic int pick_rob();
    int  r;
    bit  used;
    do begin
      r    = $urandom_range(0, 31);
      used = 1'b0;
      foreach (m_q[i]) if (m_q[i].rob_index == ROB_W'(r)) used = 1'b1;
    end while (used);
    return r;
  endfunction

  initial begin
    reset = 1'b1; disp_valid = 1'b0; disp_data = '0; cdb_valid = '0; cdb_tag = '0;
    fu_b_ready = 1'b0; mispredict = 1'b0; mispredict_tag = '0; curr_rob_tag = '0;
    m_iss = 1'b0; m_dout = '0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;

    // Reset state
    #1;
    chk("rst_issued", 128'(issued), 128'(0));
    chk("rst_dout", 128'(data_out), 128'(0));
    chk("rst_disp_ready", 128'(disp_ready), 128'(1));
    @(negedge clk);

    // Ready dispatch issues exactly one cycle later
    fu_b_ready = 1'b1;
    disp(mk(3, 1, 1, 2, 1));
    chk("rdy_not_early", 128'(issued), 128'(0));
    step();
    chk("rdy_issued", 128'(issued), 128'(1));
    chk("rdy_rob", 128'(data_out.rob_index), 128'(3));
    step();

    // Wakeup two cycles after dispatch
    disp(mk(4, 20, 0, 0, 1));
    step();
    cdb_valid = 3'b001; cdb_tag[0] = 7'd20;
    step();
    chk("wk_not_same", 128'(issued), 128'(0));
    cdb_valid = '0;
    step();
    chk("wk_issued", 128'(issued), 128'(1));
    chk("wk_rob", 128'(data_out.rob_index), 128'(4));

    // Wakeup in the dispatch cycle itself
    cdb_valid = 3'b001; cdb_tag[0] = 7'd20;
    disp(mk(7, 20, 0, 0, 1));
    cdb_valid = '0;
    step();
    chk("wkd_issued", 128'(issued), 128'(1));
    chk("wkd_rob", 128'(data_out.rob_index), 128'(7));

    // Age order across the ROB wrap
    fu_b_ready = 1'b0; curr_rob_tag = 5'd30;
    disp(mk(1, 0, 1, 0, 1));
    disp(mk(31, 0, 1, 0, 1));
    disp(mk(5, 0, 1, 0, 1));
    step();
    fu_b_ready = 1'b1;
    step(); chk("age_0", 128'(data_out.rob_index), 128'(31));
    step(); chk("age_1", 128'(data_out.rob_index), 128'(1));
    step(); chk("age_2", 128'(data_out.rob_index), 128'(5));
    step(); chk("age_done", 128'(issued), 128'(0));

    // Full station
    curr_rob_tag = 5'd0; fu_b_ready = 1'b0;
    for (int i = 0; i < 8; i++) disp(mk(10 + i, 40 + i, 0, 0, 1));
    #1 chk("full_rdy", 128'(disp_ready), 128'(0));
    @(negedge clk);
    disp(mk(20, 0, 1, 0, 1));
    fu_b_ready = 1'b1;
    cdb_valid = 3'b010; cdb_tag[1] = 7'd43;
    step();
    cdb_valid = '0;
    step();
    chk("full_iss_rob", 128'(data_out.rob_index), 128'(13));
    #1 chk("full_rdy_back", 128'(disp_ready), 128'(1));
    @(negedge clk);
    do_reset();

    // Flush of younger entries
    curr_rob_tag = 5'd0; fu_b_ready = 1'b1;
    disp(mk(2, 50, 0, 0, 1));
    disp(mk(6, 50, 0, 0, 1));
    disp(mk(9, 50, 0, 0, 1));
    mispredict = 1'b1; mispredict_tag = 5'd5;
    step();
    mispredict = 1'b0;
    cdb_valid = 3'b100; cdb_tag[2] = 7'd50;
    step();
    cdb_valid = '0;
    step();
    chk("fl_issued", 128'(issued), 128'(1));
    chk("fl_rob", 128'(data_out.rob_index), 128'(2));
    step();
    chk("fl_no_more", 128'(issued), 128'(0));

    // Reset in the middle of traffic
    fu_b_ready = 1'b0;
    for (int i = 0; i < 4; i++) disp(mk(12 + i, 0, 1, 0, 1));
    fu_b_ready = 1'b1;
    reset = 1'b1;
    step();
    chk("mr_issued", 128'(issued), 128'(0));
    reset = 1'b0;
    #1 chk("mr_rdy", 128'(disp_ready), 128'(1));
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(0, 249) == 0);
      fu_b_ready     = ($urandom_range(0, 3) != 0);
      mispredict     = ($urandom_range(0, 24) == 0);
      mispredict_tag = ROB_W'($urandom);
      if ($urandom_range(0, 15) == 0) curr_rob_tag = ROB_W'($urandom);
      disp_valid = $urandom_range(0, 1);
      disp_data  = mk(pick_rob(), $urandom_range(0, 15), $urandom_range(0, 1),
                      $urandom_range(0, 15), $urandom_range(0, 1));
      cdb_valid = NUM_CDB'($urandom);
      for (int p = 0; p < NUM_CDB; p++) cdb_tag[p] = PREG_W'($urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
